ddr_line_reader: RTL and testbench
==================================

Name: ddr_line_reader

Overview:
Parametrised DDR read engine for the capture path. It fetches a video frame line by line from one of two DDR frame buffers and forwards the returned read beats to an external line FIFO. Command issue is throttled by FIFO credit so that returned data can never overflow the FIFO. The next line is fetched on a consumer request; any clock-domain crossing and FIFO instance live outside this block.

Parameters:
ADDR_W, 29, DDR address width
DATA_W, 256, DDR read data width
ADDR_INC, 8, address increment per read command
CMDS_PER_LINE, 30, read commands per line
LINES_PER_FRAME, 160, lines per frame
BEATS_PER_CMD, 1, read-data beats returned per command
FRAME_BASE0, 0, start address of buffer 0
FRAME_BASE1, 65536, start address of buffer 1
CNT_W, 11, width of the FIFO free-space count and of the outstanding-beat counter

Ports:
clk  in  1  system/DDR user clock
rst_n  in  1  asynchronous active-low reset
init_calib_complete  in  1  DDR ready
frame_start  in  1  pulse: start a frame
frame_sel  in  1  buffer select, sampled with frame_start
line_req  in  1  pulse: consumer wants the next line
ddr_cmd_rdy  in  1  DDR controller accepts a command
ddr_cmd  out  3  constant 3'd1 (read)
ddr_cmd_en  out  1  command valid
ddr_addr  out  ADDR_W  command address
ddr_rd_data_valid  in  1  read beat valid
ddr_rd_data  in  DATA_W  read beat
fifo_free  in  CNT_W  free entries in the line FIFO
fifo_wr_en  out  1  FIFO write
fifo_wr_data  out  DATA_W  FIFO data
busy  out  1  high in every state except IDLE
line_idx  out  8  index of the current line
frame_done  out  1  one-cycle pulse when the last line has drained
err  out  3  sticky error flags; bit0 start_overrun, bit1 req_overrun, bit2 unexpected_beat
err_clr  in  1  clears err

Behaviour:
- Reset: all outputs 0, except ddr_cmd, which is always 3'd1. FSM goes to IDLE; all counters clear. Reset is effective immediately, including mid-operation.
- FSM states: IDLE, ISSUE, DRAIN, WAIT_LINE.
- IDLE:
  - frame_start && init_calib_complete: load ddr_addr = frame_sel ? FRAME_BASE1 : FRAME_BASE0; line_idx = 0; cmd_cnt = 0; go to ISSUE. The first line is fetched without a line_req.
  - frame_start without calibration: ignored.
- ISSUE:
  - ddr_cmd_en = ddr_cmd_rdy && credit_ok, where credit_ok = (fifo_free - outstanding) >= BEATS_PER_CMD. Compute at CNT_W+1 bits; a negative result means no credit.
  - A command is accepted on a cycle with ddr_cmd_en && ddr_cmd_rdy. On acceptance: ddr_addr += ADDR_INC (modulo 2^ADDR_W), cmd_cnt += 1, outstanding += BEATS_PER_CMD.
  - When the command with cmd_cnt == CMDS_PER_LINE-1 is accepted: go to DRAIN and clear cmd_cnt.
- Address continuity: ddr_addr is never reloaded between lines. Lines are contiguous, so line n starts at base + n*CMDS_PER_LINE*ADDR_INC.
- outstanding update: decrements by 1 on each ddr_rd_data_valid. When a command acceptance and a beat land in the same cycle, apply both (net +BEATS_PER_CMD-1).
- DRAIN: when outstanding == 0 (registered value):
  - if line_idx == LINES_PER_FRAME-1: pulse frame_done for one cycle, go to IDLE;
  - else go to WAIT_LINE.
- WAIT_LINE:
  - line_req or pending_req: line_idx += 1, clear pending_req, go to ISSUE.
  - A line_req arriving in ISSUE or DRAIN sets the one-deep pending_req.
  - A line_req while pending_req is already set sets err[1].
  - A line_req in IDLE is ignored.
- frame_start while busy: ignored, sets err[0].
- Data path:
  - fifo_wr_en = ddr_rd_data_valid and fifo_wr_data = ddr_rd_data, combinational, zero latency.
  - A beat arriving with outstanding == 0 is still forwarded; it sets err[2] and outstanding stays at 0 (no underflow).
- err_clr clears all err bits. A set and a clear in the same cycle leave the bit set.

Test Plan:
1. Default params, frame_sel=0, fifo_free=1024, ddr_cmd_rdy=1 -> 30 commands, addresses 0,8,...,232; DRAIN after the 30th beat; WAIT_LINE with busy=1.
2. Continue with 159 line_req pulses -> the second line starts at address 240; after the 160th line drains, frame_done pulses once, ddr_addr=38400, IDLE.
3. frame_sel=1 -> first address 65536. frame_start mid-frame -> ignored, err=3'b001; err_clr -> err=0.
4. Credit throttling: fifo_free=3, data returned 5 cycles late -> never more than 3 outstanding; ddr_cmd_en low while credit is exhausted.
5. Simultaneous command acceptance and ddr_rd_data_valid -> outstanding nets correctly. Two line_req pulses during DRAIN -> err[1] set, one extra line fetched.
6. rst_n low during ISSUE -> outputs 0 and IDLE immediately. Stray valid beat in IDLE -> forwarded to the FIFO, err[2] set.

Source files
------------

// File: rtl/ddr_line_reader.sv
// DDR read engine: fetches a video frame line by line from one of two frame
// buffers and streams the returned beats into an external line FIFO.
module ddr_line_reader #(
  parameter int ADDR_W          = 29,
  parameter int DATA_W          = 256,
  parameter int ADDR_INC        = 8,
  parameter int CMDS_PER_LINE   = 30,
  parameter int LINES_PER_FRAME = 160,
  parameter int BEATS_PER_CMD   = 1,
  parameter int FRAME_BASE0     = 0,
  parameter int FRAME_BASE1     = 65536,
  parameter int CNT_W           = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              frame_start,
  input  logic              frame_sel,
  input  logic              line_req,
  input  logic              ddr_cmd_rdy,
  output logic [2:0]        ddr_cmd,
  output logic              ddr_cmd_en,
  output logic [ADDR_W-1:0] ddr_addr,
  input  logic              ddr_rd_data_valid,
  input  logic [DATA_W-1:0] ddr_rd_data,
  input  logic [CNT_W-1:0]  fifo_free,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic [7:0]        line_idx,
  output logic              frame_done,
  output logic [2:0]        err,
  input  logic              err_clr
);

  localparam int                CMD_W     = (CMDS_PER_LINE > 1) ? $clog2(CMDS_PER_LINE) : 1;
  localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(FRAME_BASE0);
  localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(FRAME_BASE1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(ADDR_INC);
  localparam logic [CMD_W-1:0]  LAST_CMD  = CMD_W'(CMDS_PER_LINE - 1);
  localparam logic [7:0]        LAST_LINE = 8'(LINES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  BEATS     = CNT_W'(BEATS_PER_CMD);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    DRAIN     = 2'd2,
    WAIT_LINE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CMD_W-1:0] cmd_cnt;
  logic [CNT_W-1:0] outstanding, outstanding_nxt;
  logic             pending_req;
  logic [CNT_W:0]   credit_diff;
  logic             credit_ok;
  logic             start_frame;
  logic             next_line;
  logic             beat_dec;
  logic [2:0]       err_set;

  assign ddr_cmd      = 3'd1;
  assign busy         = (state != IDLE);
  assign fifo_wr_en   = ddr_rd_data_valid & rst_n;
  assign fifo_wr_data = rst_n ? ddr_rd_data : '0;

  // Free space minus beats already in flight; a negative difference means no credit.
  assign credit_diff = {1'b0, fifo_free} - {1'b0, outstanding};
  assign credit_ok   = !credit_diff[CNT_W] && (credit_diff >= {1'b0, BEATS});

  // A beat with nothing outstanding is forwarded but never decrements below zero.
  assign beat_dec = ddr_rd_data_valid && (outstanding != '0);

  assign err_set = {ddr_rd_data_valid && (outstanding == '0),
                    line_req && pending_req && busy,
                    frame_start && busy};

  always_comb begin
    outstanding_nxt = outstanding;
    if (ddr_cmd_en) outstanding_nxt = outstanding_nxt + BEATS;
    if (beat_dec)   outstanding_nxt = outstanding_nxt - ONE;
  end

  always_comb begin
    state_nxt   = state;
    ddr_cmd_en  = 1'b0;
    frame_done  = 1'b0;
    start_frame = 1'b0;
    next_line   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start && init_calib_complete) begin
          start_frame = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        ddr_cmd_en = ddr_cmd_rdy && credit_ok;
        if (ddr_cmd_en && (cmd_cnt == LAST_CMD)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0) begin
          if (line_idx == LAST_LINE) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = WAIT_LINE;
          end
        end
      end
      WAIT_LINE: begin
        if (line_req || pending_req) begin
          next_line = 1'b1;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Address runs on across lines: each line starts where the previous one ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr_addr <= '0;
      cmd_cnt  <= '0;
      line_idx <= '0;
    end else if (start_frame) begin
      ddr_addr <= frame_sel ? BASE1 : BASE0;
      cmd_cnt  <= '0;
      line_idx <= '0;
    end else begin
      if (ddr_cmd_en) begin
        ddr_addr <= ddr_addr + ADDR_STEP;
        cmd_cnt  <= (cmd_cnt == LAST_CMD) ? '0 : cmd_cnt + 1'b1;
      end
      if (next_line) line_idx <= line_idx + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding <= '0;
    else        outstanding <= outstanding_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   pending_req <= 1'b0;
    else if (next_line)                           pending_req <= 1'b0;
    else if (line_req && (state == ISSUE || state == DRAIN)) pending_req <= 1'b1;
  end

  // Setting wins over clearing so an error in the clear cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= '0;
    else        err <= (err & ~{3{err_clr}}) | err_set;
  end

endmodule

// File: tb/tb_ddr_line_reader.sv
// Self-checking bench for ddr_line_reader: a DDR responder with random latency
// and a transaction-level model of addresses, credit and line/frame progress.
module tb_ddr_line_reader;

  localparam int ADDR_W   = 29;
  localparam int DATA_W   = 256;
  localparam int CNT_W    = 11;
  localparam int CMDS     = 30;
  localparam int LINES    = 160;
  localparam int ADDR_INC = 8;
  localparam int BASE1    = 65536;
  localparam int BUDGET   = 2000;

  logic              clk;
  logic              rst_n;
  logic              init_calib_complete;
  logic              frame_start;
  logic              frame_sel;
  logic              line_req;
  logic              ddr_cmd_rdy;
  logic [2:0]        ddr_cmd;
  logic              ddr_cmd_en;
  logic [ADDR_W-1:0] ddr_addr;
  logic              ddr_rd_data_valid;
  logic [DATA_W-1:0] ddr_rd_data;
  logic [CNT_W-1:0]  fifo_free;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              busy;
  logic [7:0]        line_idx;
  logic              frame_done;
  logic [2:0]        err;
  logic              err_clr;

  ddr_line_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_INC(ADDR_INC), .CMDS_PER_LINE(CMDS),
    .LINES_PER_FRAME(LINES), .BEATS_PER_CMD(1), .FRAME_BASE0(0),
    .FRAME_BASE1(BASE1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .frame_start(frame_start), .frame_sel(frame_sel), .line_req(line_req),
    .ddr_cmd_rdy(ddr_cmd_rdy), .ddr_cmd(ddr_cmd), .ddr_cmd_en(ddr_cmd_en),
    .ddr_addr(ddr_addr), .ddr_rd_data_valid(ddr_rd_data_valid),
    .ddr_rd_data(ddr_rd_data), .fifo_free(fifo_free), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .busy(busy), .line_idx(line_idx),
    .frame_done(frame_done), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder knobs and the transaction-level model state.
  int   ret_q[$];
  int   cyc, last_due, lat_min, lat_max;
  bit   rdy_rand, force_beat, abort_run;
  int   model_out, max_out, frame_cmds, exp_addr;
  logic [ADDR_W-1:0] first_addr;
  bit   stray_fwd;
  int   addr_err, data_err, cmd_err, credit_viol, stall_viol, throttle_seen;
  int   sim_events, fd_count, line_err;
  int   n_pass, n_total;

  function automatic logic [DATA_W-1:0] randData();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // One clock per iteration: drive at the falling edge, observe just before the rising edge.
  task automatic applyStimulus(input int n);
    bit acc, beat, credit, forced;
    int lat, due;
    for (int k = 0; k < n; k++) begin
      forced = 1'b0;
      if (force_beat) begin
        forced            = 1'b1;
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data       = randData();
      end else if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
        due               = ret_q.pop_front();
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data       = randData();
      end else begin
        ddr_rd_data_valid = 1'b0;
      end
      ddr_cmd_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #3;
      beat   = ddr_rd_data_valid;
      acc    = (ddr_cmd_en === 1'b1) && ddr_cmd_rdy;
      credit = (int'(fifo_free) - model_out) >= 1;
      if (fifo_wr_en !== beat || (beat && fifo_wr_data !== ddr_rd_data)) data_err++;
      if (forced) stray_fwd = (fifo_wr_en === 1'b1) && (fifo_wr_data === ddr_rd_data);
      if (ddr_cmd !== 3'd1) cmd_err++;
      if (ddr_cmd_en === 1'b1 && (!credit || !ddr_cmd_rdy)) credit_viol++;
      if ((frame_cmds % CMDS) != 0 && ddr_cmd_rdy && credit && ddr_cmd_en !== 1'b1) stall_viol++;
      if ((frame_cmds % CMDS) != 0 && !credit && ddr_cmd_en === 1'b0) throttle_seen++;
      if (frame_done === 1'b1) fd_count++;
      if (acc) begin
        if (frame_cmds == 0) first_addr = ddr_addr;
        if (ddr_addr !== ADDR_W'(exp_addr)) addr_err++;
        exp_addr   += ADDR_INC;
        frame_cmds++;
        lat = $urandom_range(lat_min, lat_max);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ret_q.push_back(due);
      end
      if (acc && beat) sim_events++;
      model_out = model_out + (acc ? 1 : 0) - ((beat && !forced && model_out > 0) ? 1 : 0);
      if (model_out > max_out) max_out = model_out;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic waitCmds(input int target);
    int k;
    k = 0;
    while (!abort_run && frame_cmds < target && k < BUDGET) begin
      applyStimulus(1);
      k++;
    end
    if (!abort_run && frame_cmds < target) begin
      checkOutput("cmd_wait_timeout", frame_cmds, target);
      abort_run = 1'b1;
    end
  endtask

  task automatic waitDrain(input int target);
    int k;
    k = 0;
    while (!abort_run && !(frame_cmds == target && model_out == 0) && k < BUDGET) begin
      applyStimulus(1);
      k++;
    end
    if (!abort_run && !(frame_cmds == target && model_out == 0)) begin
      checkOutput("drain_timeout_cmds", frame_cmds, target);
      checkOutput("drain_timeout_outstanding", model_out, 0);
      abort_run = 1'b1;
    end
  endtask

  task automatic pulseLineReq();
    line_req = 1'b1;
    applyStimulus(1);
    line_req = 1'b0;
  endtask

  task automatic startFrame(input bit sel);
    frame_sel   = sel;
    frame_start = 1'b1;
    exp_addr    = sel ? BASE1 : 0;
    frame_cmds  = 0;
    applyStimulus(1);
    frame_start = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; init_calib_complete = 1'b1; frame_start = 1'b0; frame_sel = 1'b0;
    line_req = 1'b0; ddr_cmd_rdy = 1'b1; ddr_rd_data_valid = 1'b0; ddr_rd_data = '0;
    fifo_free = 11'd1024; err_clr = 1'b0;
    cyc = 0; last_due = 0; lat_min = 1; lat_max = 4; rdy_rand = 0; force_beat = 0;
    abort_run = 0; model_out = 0; max_out = 0; frame_cmds = 0; exp_addr = 0;
    first_addr = '0; stray_fwd = 0; addr_err = 0; data_err = 0; cmd_err = 0;
    credit_viol = 0; stall_viol = 0; throttle_seen = 0; sim_events = 0;
    fd_count = 0; line_err = 0; n_pass = 0; n_total = 0;

    // Reset state
    @(negedge clk);
    applyStimulus(3);
    checkOutput("reset_cmd", ddr_cmd, 3'd1);
    checkOutput("reset_cmd_en", ddr_cmd_en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_addr", ddr_addr, 0);
    checkOutput("reset_line_idx", line_idx, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;
    applyStimulus(2);

    // Full frame from buffer 0, one line_req per line after the first
    startFrame(1'b0);
    for (int ln = 0; ln < LINES; ln++) begin
      waitDrain(CMDS * (ln + 1));
      applyStimulus(2);
      if (ln < LINES - 1) begin
        if (line_idx !== 8'(ln) || busy !== 1'b1 || ddr_cmd_en !== 1'b0 ||
            frame_cmds != CMDS * (ln + 1)) line_err++;
        if (ln == 0) begin
          checkOutput("line0_wait_busy", busy, 1);
          checkOutput("line1_start_addr", ddr_addr, 240);
        end
        pulseLineReq();
      end
    end
    checkOutput("frame0_line_progress", line_err, 0);
    checkOutput("frame0_done_pulses", fd_count, 1);
    checkOutput("frame0_end_addr", ddr_addr, 38400);
    checkOutput("frame0_idle", busy, 0);
    checkOutput("frame0_total_cmds", frame_cmds, CMDS * LINES);

    // Buffer 1 with random ready and long latency; overrun errors
    rdy_rand = 1; lat_min = 12; lat_max = 16;
    startFrame(1'b1);
    waitCmds(5);
    frame_sel = 1'b0; frame_start = 1'b1;
    applyStimulus(1);
    frame_start = 1'b0; frame_sel = 1'b1;
    checkOutput("start_overrun_err", err, 3'b001);
    err_clr = 1'b1;
    applyStimulus(1);
    err_clr = 1'b0;
    checkOutput("err_clr", err, 3'b000);
    checkOutput("sel1_first_addr", first_addr, BASE1);
    waitCmds(CMDS);
    pulseLineReq();
    applyStimulus(1);
    pulseLineReq();
    checkOutput("req_overrun_err", err, 3'b010);
    waitDrain(2 * CMDS);
    applyStimulus(3);
    checkOutput("pending_line_idx", line_idx, 1);
    checkOutput("pending_busy", busy, 1);
    checkOutput("pending_one_extra_line", frame_cmds, 2 * CMDS);
    err_clr = 1'b1;
    applyStimulus(1);
    err_clr = 1'b0;

    // Credit throttling: three free entries, fixed latency of five
    rdy_rand = 0; lat_min = 5; lat_max = 5; fifo_free = 11'd3; max_out = 0; throttle_seen = 0;
    pulseLineReq();
    waitDrain(3 * CMDS);
    applyStimulus(2);
    checkOutput("credit_max_outstanding", max_out, 3);
    checkOutput("credit_throttled", throttle_seen > 0, 1);
    checkOutput("credit_line_idx", line_idx, 2);

    // Acceptance and returning beat in the same cycle
    fifo_free = 11'd1024; lat_min = 2; lat_max = 2; sim_events = 0;
    pulseLineReq();
    waitDrain(4 * CMDS);
    applyStimulus(2);
    checkOutput("same_cycle_seen", sim_events > 0, 1);
    pulseLineReq();
    checkOutput("line_after_same_cycle", line_idx, 4);

    // Reset in the middle of ISSUE
    waitCmds(4 * CMDS + 10);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_cmd_en", ddr_cmd_en, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_addr", ddr_addr, 0);
    checkOutput("midreset_line_idx", line_idx, 0);
    checkOutput("midreset_err", err, 0);
    checkOutput("midreset_fifo_wr_en", fifo_wr_en, 0);
    checkOutput("midreset_cmd", ddr_cmd, 3'd1);
    ret_q.delete(); model_out = 0; frame_cmds = 0; last_due = 0;
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(1);

    // Stray beat while idle, ignored requests while idle or uncalibrated
    force_beat = 1;
    applyStimulus(1);
    force_beat = 0;
    checkOutput("stray_forwarded", stray_fwd, 1);
    checkOutput("stray_err", err, 3'b100);
    checkOutput("stray_idle", busy, 0);
    err_clr = 1'b1;
    applyStimulus(1);
    err_clr = 1'b0;
    checkOutput("stray_err_clr", err, 3'b000);
    init_calib_complete = 1'b0;
    frame_start = 1'b1;
    applyStimulus(1);
    frame_start = 1'b0;
    applyStimulus(2);
    checkOutput("uncal_start_ignored", busy, 0);
    init_calib_complete = 1'b1;
    pulseLineReq();
    applyStimulus(1);
    checkOutput("idle_req_ignored_busy", busy, 0);
    checkOutput("idle_req_ignored_err", err, 3'b000);

    // Accumulated per-cycle observations
    checkOutput("addr_sequence", addr_err, 0);
    checkOutput("data_forwarding", data_err, 0);
    checkOutput("cmd_constant", cmd_err, 0);
    checkOutput("credit_respected", credit_viol, 0);
    checkOutput("no_stall_with_credit", stall_viol, 0);
    checkOutput("total_done_pulses", fd_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
